// File: rtl/mem_arbiter_rr_if.sv
// Client-side and downstream line-port bundle for the memory arbiter.
// The master modport is the arbiter's view; slave is the clients/downstream environment.
interface mem_arbiter_rr_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic [NUM_PORTS-1:0]            c_read;
  logic [NUM_PORTS-1:0]            c_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] c_address;
  logic [NUM_PORTS*LINE_WIDTH-1:0] c_wdata;
  logic [LINE_WIDTH-1:0]           c_rdata;
  logic [NUM_PORTS-1:0]            c_resp;
  logic                            pmem_read;
  logic                            pmem_write;
  logic [ADDR_WIDTH-1:0]           pmem_address;
  logic [LINE_WIDTH-1:0]           pmem_wdata;
  logic [LINE_WIDTH-1:0]           pmem_rdata;
  logic                            pmem_resp;

  modport master (
    input  c_read, c_write, c_address, c_wdata, pmem_rdata, pmem_resp,
    output c_rdata, c_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    output c_read, c_write, c_address, c_wdata, pmem_rdata, pmem_resp,
    input  c_rdata, c_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// N-client line-memory arbiter: one granted client at a time drives the downstream
// line port, chosen round-robin or by fixed priority (port 0 highest).
module mem_arbiter_rr #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int ROUND_ROBIN = 1,
  parameter int GID_W       = $clog2(NUM_PORTS)
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_rr_if.master  bus,
  output logic              busy,
  output logic [GID_W-1:0]  grant_id
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_reg, state_next;
  logic [GID_W-1:0]       grant_reg, grant_next;
  logic [GID_W-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [GID_W-1:0]       sel_idx;
  logic [NUM_PORTS-1:0]   req;
  logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_PORTS];
  logic [LINE_WIDTH-1:0]  wdata_arr [NUM_PORTS];

  assign req = bus.c_read | bus.c_write;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.c_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = bus.c_wdata[gi*LINE_WIDTH +: LINE_WIDTH];
    end
  endgenerate

  generate
    if (ROUND_ROBIN != 0) begin : g_rr
      // Scan offsets from farthest to nearest so the nearest requester after rr_ptr wins.
      logic [GID_W:0] idx;
      always_comb begin
        sel_idx = '0;
        idx     = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
          idx = {1'b0, rr_ptr_reg} + (GID_W+1)'(k);
          if (idx >= (GID_W+1)'(NUM_PORTS)) begin
            idx = idx - (GID_W+1)'(NUM_PORTS);
          end
          if (req[idx[GID_W-1:0]]) begin
            sel_idx = idx[GID_W-1:0];
          end
        end
      end
    end else begin : g_fp
      always_comb begin
        sel_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
          if (req[GID_W'(i)]) begin
            sel_idx = GID_W'(i);
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= GID_W'(NUM_PORTS - 1);
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    rr_ptr_next      = rr_ptr_reg;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    bus.c_resp       = '0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next = BUSY;
          grant_next = sel_idx;
        end
      end
      BUSY: begin
        // Write wins when a client raises both strobes.
        bus.pmem_write   = bus.c_write[grant_reg];
        bus.pmem_read    = bus.c_read[grant_reg] & ~bus.c_write[grant_reg];
        bus.pmem_address = addr_arr[grant_reg];
        bus.pmem_wdata   = wdata_arr[grant_reg];
        if (bus.pmem_resp) begin
          bus.c_resp[grant_reg] = 1'b1;
          state_next            = IDLE;
          if (ROUND_ROBIN != 0) begin
            rr_ptr_next = grant_reg;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.c_rdata = bus.pmem_rdata;
  assign busy        = (state_reg == BUSY);
  assign grant_id    = grant_reg;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: vector table and hand sequences on a 3-port round-robin
// and a 3-port fixed-priority instance, then random traffic against a reference model.
module tb_mem_arbiter_rr;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int LW = 64;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_rr_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) ifa ();
  mem_arbiter_rr_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) ifb ();

  logic          busy_a, busy_b;
  logic [GW-1:0] gid_a, gid_b;

  mem_arbiter_rr #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .ROUND_ROBIN(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .busy(busy_a), .grant_id(gid_a));
  mem_arbiter_rr #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .ROUND_ROBIN(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .busy(busy_b), .grant_id(gid_b));

  logic [N-1:0]  a_rd, a_wr, b_rd, b_wr;
  logic          a_resp, b_resp;
  logic [AW-1:0] a_addr [N];
  logic [LW-1:0] a_wd   [N];
  logic [LW-1:0] rdata;

  logic [AW-1:0] A_C [N] = '{32'h0000_2000, 32'h0000_1040, 32'h0000_3080};
  logic [LW-1:0] W_C [N] = '{64'hDEAD_BEEF_DEAD_BEEF, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};

  assign ifa.c_read = a_rd;  assign ifa.c_write = a_wr;  assign ifa.pmem_resp = a_resp;
  assign ifb.c_read = b_rd;  assign ifb.c_write = b_wr;  assign ifb.pmem_resp = b_resp;
  assign ifa.pmem_rdata = rdata;
  assign ifb.pmem_rdata = rdata;
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign ifa.c_address[gi*AW +: AW] = a_addr[gi];
      assign ifa.c_wdata[gi*LW +: LW]   = a_wd[gi];
      assign ifb.c_address[gi*AW +: AW] = a_addr[gi];
      assign ifb.c_wdata[gi*LW +: LW]   = a_wd[gi];
    end
  endgenerate

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected downstream values come from the bench's own stimulus for the expected port.
  task automatic expect_a(input string tag, input logic eb, input logic [GW-1:0] eg,
                          input logic epr, input logic epw, input logic [N-1:0] ecr);
    chk({tag, ".busy"},  64'(busy_a), 64'(eb));
    chk({tag, ".gid"},   64'(gid_a), 64'(eg));
    chk({tag, ".pread"}, 64'(ifa.pmem_read), 64'(epr));
    chk({tag, ".pwrite"},64'(ifa.pmem_write), 64'(epw));
    chk({tag, ".cresp"}, 64'(ifa.c_resp), 64'(ecr));
    chk({tag, ".paddr"}, 64'(ifa.pmem_address), eb ? 64'(a_addr[eg]) : 64'd0);
    chk({tag, ".pwdata"}, ifa.pmem_wdata, eb ? a_wd[eg] : 64'd0);
    chk({tag, ".crdata"}, ifa.c_rdata, rdata);
  endtask

  task automatic expect_b(input string tag, input logic eb, input logic [GW-1:0] eg,
                          input logic [N-1:0] ecr);
    chk({tag, ".busy"},  64'(busy_b), 64'(eb));
    chk({tag, ".gid"},   64'(gid_b), 64'(eg));
    chk({tag, ".cresp"}, 64'(ifb.c_resp), 64'(ecr));
  endtask

  typedef struct {
    logic [N-1:0]  rd, wr;
    logic          resp, busy;
    logic [GW-1:0] gid;
    logic          pr, pw;
    logic [N-1:0]  cresp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [N-1:0] rd, input logic [N-1:0] wr, input logic resp,
                     input logic busy, input logic [GW-1:0] gid, input logic pr,
                     input logic pw, input logic [N-1:0] cresp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.resp = resp; v.busy = busy;
    v.gid = gid; v.pr = pr; v.pw = pw; v.cresp = cresp;
    tbl.push_back(v);
  endtask

  // Reference model state: granted client (-1 when idle), last served client, grant index.
  int m_cur, m_last, m_gid;
  logic [N-1:0] active, drop;

  initial begin
    rst = 1'b1;
    a_rd = '0; a_wr = '0; b_rd = '0; b_wr = '0; a_resp = 1'b0; b_resp = 1'b0;
    rdata = {8{8'hA5}};
    for (int i = 0; i < N; i++) begin a_addr[i] = A_C[i]; a_wd[i] = W_C[i]; end

    // Round-robin fairness from reset: 0,1,2,0,1 with one idle cycle between grants.
    add(3'b111, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000);
    add(3'b111, 3'b000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 3'b001);
    add(3'b111, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000);
    add(3'b111, 3'b000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 3'b010);
    add(3'b111, 3'b000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 3'b000);
    add(3'b111, 3'b000, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 3'b100);
    add(3'b111, 3'b000, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 3'b000);
    add(3'b111, 3'b000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 3'b001);
    add(3'b111, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000);
    add(3'b111, 3'b000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 3'b010);
    add(3'b000, 3'b000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 3'b000);
    // Stray response while idle, then pointer still at 1 so port 2 beats port 0.
    add(3'b000, 3'b000, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 3'b000);
    add(3'b101, 3'b000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 3'b000);
    add(3'b101, 3'b000, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 3'b100);
    add(3'b000, 3'b000, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 3'b000);
    // Read+write on port 0: write wins.
    add(3'b001, 3'b001, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 3'b000);
    add(3'b001, 3'b001, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 3'b000);
    add(3'b001, 3'b001, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 3'b001);
    // Single requester on port 1, response three cycles after the request.
    add(3'b010, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000);
    add(3'b010, 3'b000, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 3'b000);
    add(3'b010, 3'b000, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 3'b000);
    add(3'b010, 3'b000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 3'b010);
    // Port 2 drops its request mid-grant: strobes follow it, grant stays until response.
    add(3'b100, 3'b000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 3'b000);
    add(3'b100, 3'b000, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 3'b000);
    add(3'b000, 3'b000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 3'b000);
    add(3'b000, 3'b000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 3'b100);
    add(3'b000, 3'b000, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 3'b000);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_a("reset", 1'b0, 2'd0, 1'b0, 1'b0, 3'b000);
    expect_b("reset_b", 1'b0, 2'd0, 3'b000);
    @(negedge clk);

    foreach (tbl[i]) begin
      a_rd = tbl[i].rd; a_wr = tbl[i].wr; a_resp = tbl[i].resp;
      #1;
      $display("row %0d rd=%b wr=%b resp=%b -> busy=%b gid=%0d cresp=%b",
               i, a_rd, a_wr, a_resp, busy_a, gid_a, ifa.c_resp);
      expect_a($sformatf("row%0d", i), tbl[i].busy, tbl[i].gid, tbl[i].pr, tbl[i].pw, tbl[i].cresp);
      @(negedge clk);
    end

    // Reset while port 1 is granted (pointer at 0); afterwards the search restarts at port 0.
    a_rd = 3'b001; a_resp = 1'b0; @(negedge clk);
    a_resp = 1'b1; #1; expect_a("rst_pre0", 1'b1, 2'd0, 1'b1, 1'b0, 3'b001); @(negedge clk);
    a_rd = 3'b010; a_resp = 1'b0; @(negedge clk);
    #1; expect_a("rst_busy1", 1'b1, 2'd1, 1'b1, 1'b0, 3'b000); @(negedge clk);
    rst = 1'b1; a_rd = 3'b111; @(negedge clk);
    rst = 1'b0; a_resp = 1'b1;
    #1; expect_a("rst_after", 1'b0, 2'd0, 1'b0, 1'b0, 3'b000);
    $display("reset mid-op: busy=%b pread=%b", busy_a, ifa.pmem_read);
    @(negedge clk);
    a_resp = 1'b0;
    #1; expect_a("rst_regrant", 1'b1, 2'd0, 1'b1, 1'b0, 3'b000); @(negedge clk);
    a_resp = 1'b1; @(negedge clk);
    a_rd = '0; a_resp = 1'b0; @(negedge clk);

    // Fixed priority: port 0 always wins over port 2 until it lets go.
    b_rd = 3'b101;
    for (int k = 0; k < 2; k++) begin
      b_resp = 1'b0; #1; expect_b($sformatf("fp_idle%0d", k), 1'b0, 2'd0, 3'b000); @(negedge clk);
      b_resp = 1'b1; #1; expect_b($sformatf("fp_g0_%0d", k), 1'b1, 2'd0, 3'b001);
      $display("fixed priority grant %0d -> gid=%0d", k, gid_b);
      @(negedge clk);
    end
    b_rd = 3'b100; b_resp = 1'b0; #1; expect_b("fp_idle2", 1'b0, 2'd0, 3'b000); @(negedge clk);
    b_resp = 1'b1; #1; expect_b("fp_g2", 1'b1, 2'd2, 3'b100);
    $display("fixed priority grant 2 -> gid=%0d", gid_b);
    @(negedge clk);
    b_rd = '0; b_resp = 1'b0;

    // Random traffic on the round-robin instance.
    rst = 1'b1; a_rd = '0; a_wr = '0; a_resp = 1'b0; @(negedge clk);
    rst = 1'b0;
    m_cur = -1; m_last = N - 1; m_gid = 0; active = '0; drop = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic          e_busy, e_pr, e_pw;
      logic [N-1:0]  e_cr;
      logic [AW-1:0] e_addr;
      logic [LW-1:0] e_wd;
      for (int i = 0; i < N; i++) begin
        if (drop[i]) begin
          a_rd[i] = 1'b0; a_wr[i] = 1'b0; active[i] = 1'b0; drop[i] = 1'b0;
        end else if (!active[i] && $urandom_range(0, 3) == 0) begin
          int op;
          op = $urandom_range(1, 3);
          a_rd[i] = op[0]; a_wr[i] = op[1];
          a_addr[i] = $urandom; a_wd[i] = {$urandom, $urandom};
          active[i] = 1'b1;
        end
      end
      a_resp = ($urandom_range(0, 2) == 0);
      rdata  = {$urandom, $urandom};
      #1;
      e_busy = (m_cur >= 0); e_pr = 1'b0; e_pw = 1'b0; e_cr = '0; e_addr = '0; e_wd = '0;
      if (m_cur >= 0) begin
        e_pw   = a_wr[m_cur];
        e_pr   = a_rd[m_cur] & ~a_wr[m_cur];
        e_addr = a_addr[m_cur];
        e_wd   = a_wd[m_cur];
        if (a_resp) e_cr = N'(1 << m_cur);
      end
      chk("rnd.busy",   64'(busy_a), 64'(e_busy));
      chk("rnd.gid",    64'(gid_a), 64'(m_gid));
      chk("rnd.pread",  64'(ifa.pmem_read), 64'(e_pr));
      chk("rnd.pwrite", 64'(ifa.pmem_write), 64'(e_pw));
      chk("rnd.cresp",  64'(ifa.c_resp), 64'(e_cr));
      chk("rnd.paddr",  64'(ifa.pmem_address), 64'(e_addr));
      chk("rnd.pwdata", ifa.pmem_wdata, e_wd);
      chk("rnd.crdata", ifa.c_rdata, rdata);
      if (e_cr != '0) begin
        $display("txn cyc=%0d port=%0d %s addr=%h", cyc, m_cur,
                 e_pw ? "write" : "read", e_addr);
      end
      @(posedge clk);
      // Model: idle picks the first requester after the last served one, modulo N.
      if (m_cur < 0) begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_last + k) % N;
          if (m_cur < 0 && (a_rd[i] | a_wr[i])) begin
            m_cur = i; m_gid = i;
          end
        end
      end else if (a_resp) begin
        drop[m_cur] = 1'b1;
        m_last = m_cur;
        m_cur  = -1;
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
